// File: rtl/code_encoder_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | code_encoder_tx                                                    |
// | Maps a decimal digit to its 4-bit code, then sends it on a framed  |
// | serial line (start bit, 4 data bits MSB first, stop bit).          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module code_encoder_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       err_invalid
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;
    localparam logic [7:0] c_cnt_max = 8'(CLKS_PER_BIT - 1);

    function automatic logic [3:0] f_encode(input logic [3:0] d);
        logic [3:0] code;
        case (d)
            4'd0:    code = 4'b0000;
            4'd1:    code = 4'b0001;
            4'd2:    code = 4'b0011;
            4'd3:    code = 4'b0010;
            4'd4:    code = 4'b0111;
            4'd5:    code = 4'b0110;
            4'd6:    code = 4'b0100;
            4'd7:    code = 4'b0101;
            4'd8:    code = 4'b1111;
            4'd9:    code = 4'b1110;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_bit_idx;
    logic [3:0] r_shift;
    logic       r_tx;
    logic       r_ready;
    logic [3:0] r_code;
    logic       r_code_valid;
    logic       r_err;

    logic [1:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] w_bit_idx_nxt;
    logic [3:0] w_shift_nxt;
    logic       w_tx_nxt;
    logic       w_hs;
    logic       w_legal;
    logic       w_bit_end;
    logic [3:0] w_code;

    assign w_hs      = digit_valid & r_ready;
    assign w_legal   = (digit_in <= 4'd9);
    assign w_bit_end = (r_cnt == c_cnt_max);
    assign w_code    = f_encode(digit_in);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_tx_nxt      = r_tx;
        case (r_state)
            c_idle: begin
                w_tx_nxt = 1'b1;
                if (w_hs && w_legal) begin
                    w_state_nxt = c_start;
                    w_cnt_nxt   = 8'd0;
                    w_shift_nxt = w_code;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_start: begin
                if (w_bit_end) begin
                    w_state_nxt   = c_data;
                    w_cnt_nxt     = 8'd0;
                    w_bit_idx_nxt = 2'd3;
                    w_tx_nxt      = r_shift[3];
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_data: begin
                if (w_bit_end) begin
                    w_cnt_nxt = 8'd0;
                    if (r_bit_idx == 2'd0) begin
                        w_state_nxt = c_stop;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        // Next bit is pre-registered so the line changes exactly on the boundary
                        w_bit_idx_nxt = r_bit_idx - 2'd1;
                        w_shift_nxt   = {r_shift[2:0], 1'b0};
                        w_tx_nxt      = r_shift[2];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            c_stop: begin
                if (w_bit_end) begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = 8'd0;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_cnt_nxt   = 8'd0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_cnt        <= 8'd0;
            r_bit_idx    <= 2'd0;
            r_shift      <= 4'd0;
            r_tx         <= 1'b1;
            r_ready      <= 1'b0;
            r_code       <= 4'd0;
            r_code_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_ready      <= (w_state_nxt == c_idle);
            r_code_valid <= w_hs && w_legal;
            r_err        <= w_hs && !w_legal;
            if (w_hs && w_legal) begin
                r_code <= w_code;
            end
        end
    end

    assign digit_ready = r_ready;
    assign code_out    = r_code;
    assign code_valid  = r_code_valid;
    assign tx_serial   = r_tx;
    assign tx_busy     = (r_state != c_idle);
    assign err_invalid = r_err;

endmodule
`default_nettype wire

// File: doc/code_encoder_tx.md
Name: code_encoder_tx

Overview:
- Encoder and serial transmitter for the team's 4-bit decimal digit code.
- Accepts a binary digit 0..9 over a valid/ready handshake and maps it to its 4-bit code word.
- Presents the code word on a registered parallel output, then shifts it out on a framed serial line.
- Feeds the existing code-to-digit decoding path, which sits at the far end of the serial link.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit-time; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_in  input  4  binary digit to encode; legal values 0..9.
- digit_valid  input  1  digit_in is valid this cycle.
- digit_ready  output  1  block can accept a digit this cycle.
- code_out  output  4  registered code word of the last accepted legal digit.
- code_valid  output  1  one-cycle pulse when code_out updates.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- err_invalid  output  1  one-cycle pulse when an illegal digit is accepted.

Behaviour:
- Clock and reset:
  - Single clock domain (clk).
  - Reset is asynchronous and active-low (rst_n).
  - Assertion of rst_n takes effect immediately, including mid-frame.
  - Outputs in reset: tx_serial=1, tx_busy=0, digit_ready=0, code_out=0000, code_valid=0, err_invalid=0, state=IDLE, all counters 0.
  - digit_ready goes high on the first clock edge after rst_n deasserts.
- Encoding table (digit -> code):
  - 0->0000, 1->0001, 2->0011, 3->0010, 4->0111
  - 5->0110, 6->0100, 7->0101, 8->1111, 9->1110
- States: IDLE, START, DATA, STOP.
  - digit_ready = (state==IDLE) and not in reset.
  - A handshake occurs when digit_valid and digit_ready are both high at a rising edge.
- Handshake with a legal digit (0..9):
  - Next cycle: code_out = encoded digit, code_valid=1 for one cycle, state=START, tx_busy=1, tx_serial=0.
  - The code word is latched into a 4-bit shift register.
- Handshake with an illegal digit (10..15):
  - The digit is consumed and not transmitted.
  - Next cycle: err_invalid=1 for one cycle; code_out holds its previous value; code_valid=0; state stays IDLE.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 4 bits sent MSB first, each held for CLKS_PER_BIT cycles.
  - A 2-bit bit-index counts 3 down to 0.
  - After bit 0 completes, go to STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - tx_busy drops and digit_ready rises in the same cycle IDLE is entered.
- Frame timing:
  - Frame = 6 bit-times = 6*CLKS_PER_BIT cycles of tx_busy=1.
  - Minimum handshake-to-handshake spacing = 6*CLKS_PER_BIT+1 cycles.
- Cycle counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on entry to START.
- digit_in and digit_valid are ignored while busy; digit_ready=0 during the whole frame.
- tx_serial is driven from a register and is glitch-free.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, then release -> tx_serial=1, tx_busy=0, code_out=0000; digit_ready=1 one cycle after release.
2. Digit 5 with CLKS_PER_BIT=4 -> code_out=0110 with a 1-cycle code_valid pulse; tx_serial sequence 0,0,1,1,0,1, each bit held 4 cycles; tx_busy=1 for exactly 24 cycles.
3. All digits 0..9 sent back-to-back with digit_valid held high -> code_out matches the table for each digit; handshakes 25 cycles apart; a model decoder of the serial stream recovers each digit.
4. digit_in=12 in IDLE -> err_invalid pulses for 1 cycle; tx_serial stays 1; code_out unchanged; digit_ready high again the next cycle.
5. Send digit 8, assert rst_n=0 during the second DATA bit -> tx_serial=1 and tx_busy=0 immediately (asynchronous); after release, digit 9 transmits cleanly as 0,1,1,1,0,1.
6. digit_valid toggled during a frame -> no extra handshakes, code_out stable until the frame ends.
